// File: rtl/os_array_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic array.
// Used by os_systolic_array and os_mac_pe.
package os_array_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FLUSH,
    DRAIN
  } os_state_e;

  // Cycles needed for the last beat to reach PE(ROWS-1,COLS-1).
  function automatic int flush_len(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Bits needed to hold the value n itself.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index n items (0..n-1).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/os_mac_pe.sv
// Single output-stationary PE: forwards operands, multiply-accumulates.
// OS_SAT_EN selects saturating accumulation with a sticky clamp flag.
module os_mac_pe
  import os_array_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic signed [IN_W-1:0]  k_i,
  input  logic                    kv_i,
  input  logic signed [IN_W-1:0]  f_i,
  input  logic                    fv_i,
  output logic signed [IN_W-1:0]  k_o,
  output logic                    kv_o,
  output logic signed [IN_W-1:0]  f_o,
  output logic                    fv_o,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    sat_o
);

  logic signed [IN_W-1:0]  k_q, f_q;
  logic                    kv_q, fv_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] prod, sum;
  logic                    hit;

  assign hit  = kv_i && fv_i;
  assign prod = ACC_W'(k_i) * ACC_W'(f_i);
  assign sum  = acc_q + prod;

`ifdef OS_SAT_EN
  logic ovf;
  logic sat_q;

  assign ovf = (acc_q[ACC_W-1] == prod[ACC_W-1]) &&
               (sum[ACC_W-1] != acc_q[ACC_W-1]);

  // Clamp toward the sign of the running sum on overflow.
  always_comb begin
    acc_d = sum;
    if (ovf) begin
      acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Sticky clamp flag, cleared with the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (clr_i) begin
      sat_q <= 1'b0;
    end else if (hit && ovf) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_o = sat_q;
`else
  assign acc_d = sum;
  assign sat_o = 1'b0;
`endif

  // Valid tags and accumulator; bubbles leave the sum untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      kv_q  <= 1'b0;
      fv_q  <= 1'b0;
      acc_q <= '0;
    end else begin
      kv_q <= kv_i;
      fv_q <= fv_i;
      if (clr_i) begin
        acc_q <= '0;
      end else if (hit) begin
        acc_q <= acc_d;
      end
    end
  end

  // Operand forwarding: kernel to the right, fmap downward.
  always_ff @(posedge clk) begin
    k_q <= k_i;
    f_q <= f_i;
  end

  assign k_o   = k_q;
  assign kv_o  = kv_q;
  assign f_o   = f_q;
  assign fv_o  = fv_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/os_systolic_array.sv
// ROWSxCOLS output-stationary array: input skew, job FSM, row drain.
// OS_SAT_EN (in os_mac_pe) enables saturation and out_sat reporting.
module os_systolic_array
  import os_array_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int K_MAX = 256
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(K_MAX+1)-1:0]  k_len,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [COLS*IN_W-1:0]        fmap_in,
  input  logic [ROWS*IN_W-1:0]        kernel_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [COLS*ACC_W-1:0]       out_row,
  output logic                        out_last,
  output logic                        out_sat
);

  localparam int KW = $clog2(K_MAX + 1);
  localparam int FL = flush_len(ROWS, COLS);
  localparam int FW = cnt_w(FL);
  localparam int RW = idx_w(ROWS);

  os_state_e      state_q, state_d;
  logic [KW-1:0]  klen_q, klen_d;
  logic [KW-1:0]  beat_q, beat_d;
  logic [FW-1:0]  fl_q, fl_d;
  logic [RW-1:0]  row_q, row_d;
  logic           clr;
  logic           beat_ok;

  logic signed [IN_W-1:0]  kh  [ROWS][COLS+1];
  logic                    kvh [ROWS][COLS+1];
  logic signed [IN_W-1:0]  fh  [ROWS+1][COLS];
  logic                    fvh [ROWS+1][COLS];
  logic signed [ACC_W-1:0] acc [ROWS][COLS];
  logic                    sat [ROWS][COLS];

  assign in_ready  = (state_q == COMPUTE) && (beat_q < klen_q);
  assign beat_ok   = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid && (row_q == RW'(ROWS - 1));

  // Next-state logic for the job sequence.
  always_comb begin
    state_d = state_q;
    klen_d  = klen_q;
    beat_d  = beat_q;
    fl_d    = fl_q;
    row_d   = row_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && (k_len != '0)) begin
          klen_d  = k_len;
          beat_d  = '0;
          clr     = 1'b1;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (beat_ok) begin
          beat_d = beat_q + 1'b1;
          if ((beat_q + 1'b1) == klen_q) begin
            fl_d    = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        fl_d = fl_q + 1'b1;
        if (fl_q == FW'(FL - 1)) begin
          row_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          row_d = row_q + 1'b1;
          if (row_q == RW'(ROWS - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      klen_q  <= '0;
      beat_q  <= '0;
      fl_q    <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      klen_q  <= klen_d;
      beat_q  <= beat_d;
      fl_q    <= fl_d;
      row_q   <= row_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_kskew
    logic signed [IN_W-1:0] d_q [r+1];
    logic [r:0]             v_q;

    // Kernel lane r: input register plus r extra delay stages.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
      end else begin
        v_q[0] <= beat_ok;
        for (int i = 1; i <= r; i++) begin
          v_q[i] <= v_q[i-1];
        end
      end
      d_q[0] <= kernel_in[r*IN_W +: IN_W];
      for (int i = 1; i <= r; i++) begin
        d_q[i] <= d_q[i-1];
      end
    end

    assign kh[r][0]  = d_q[r];
    assign kvh[r][0] = v_q[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_fskew
    logic signed [IN_W-1:0] d_q [c+1];
    logic [c:0]             v_q;

    // Fmap lane c: input register plus c extra delay stages.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
      end else begin
        v_q[0] <= beat_ok;
        for (int i = 1; i <= c; i++) begin
          v_q[i] <= v_q[i-1];
        end
      end
      d_q[0] <= fmap_in[c*IN_W +: IN_W];
      for (int i = 1; i <= c; i++) begin
        d_q[i] <= d_q[i-1];
      end
    end

    assign fh[0][c]  = d_q[c];
    assign fvh[0][c] = v_q[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      os_mac_pe #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr),
        .k_i   (kh[r][c]),
        .kv_i  (kvh[r][c]),
        .f_i   (fh[r][c]),
        .fv_i  (fvh[r][c]),
        .k_o   (kh[r][c+1]),
        .kv_o  (kvh[r][c+1]),
        .f_o   (fh[r+1][c]),
        .fv_o  (fvh[r+1][c]),
        .acc_o (acc[r][c]),
        .sat_o (sat[r][c])
      );
    end
  end

  // Present the current drain row; zero outside DRAIN.
  always_comb begin
    out_row = '0;
    out_sat = 1'b0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        out_row[c*ACC_W +: ACC_W] = acc[row_q][c];
        out_sat = out_sat | sat[row_q][c];
      end
    end
  end

endmodule

// File: tb/tb_os_systolic_array.sv
// Scoreboard bench for os_systolic_array (2x2, IN_W=16, ACC_W=32).
// Directed jobs push expected rows; a monitor checks each drained row.
module tb_os_systolic_array;

  localparam int IN_W  = 16;
  localparam int ACC_W = 32;
  localparam int ROWS  = 2;
  localparam int COLS  = 2;
  localparam int K_MAX = 256;
  localparam int KW    = $clog2(K_MAX + 1);

  logic                   clk = 1'b0;
  logic                   rst, start, in_valid, out_ready;
  logic [KW-1:0]          k_len;
  logic [COLS*IN_W-1:0]   fmap_in;
  logic [ROWS*IN_W-1:0]   kernel_in;
  logic                   busy, in_ready, out_valid, out_last, out_sat;
  logic [COLS*ACC_W-1:0]  out_row;

  typedef struct {
    logic [COLS*ACC_W-1:0] row;
    logic                  last;
    logic                  sat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  os_systolic_array #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W),
    .ROWS  (ROWS),
    .COLS  (COLS),
    .K_MAX (K_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmap_in   (fmap_in),
    .kernel_in (kernel_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_last  (out_last),
    .out_sat   (out_sat)
  );

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a00, input logic [31:0] a01,
                          input logic [31:0] a10, input logic [31:0] a11,
                          input logic s0, input logic s1);
    exp_t e;
    e.row  = {a01, a00};
    e.last = 1'b0;
    e.sat  = s0;
    sb.push_back(e);
    e.row  = {a11, a10};
    e.last = 1'b1;
    e.sat  = s1;
    sb.push_back(e);
  endtask

  task automatic start_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
  endtask

  task automatic beat(input logic signed [IN_W-1:0] k0,
                      input logic signed [IN_W-1:0] k1,
                      input logic signed [IN_W-1:0] f0,
                      input logic signed [IN_W-1:0] f1,
                      input bit v);
    int n = 0;
    kernel_in = {k1, k0};
    fmap_in   = {f1, f0};
    in_valid  = v;
    if (v) begin
      while (!in_ready && n < 50) begin
        tick();
        n++;
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("job_done", busy, 0);
  endtask

  // Monitor: compare every accepted result row against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_row", out_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("row_data", out_row, e.row);
          chk("row_last", out_last, e.last);
          chk("row_sat", out_sat, e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog busy=%0b exp=0", busy);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    out_ready = 1'b1; fmap_in = '0; kernel_in = '0;
    tick();
    tick();
    chk("rst_flags", {busy, in_ready, out_valid, out_last, out_sat}, 0);
    chk("rst_row", out_row, 0);
    rst = 1'b0;
    tick();

    // k=1, kernel {2,3}, fmap {4,5}
    start_job(1);
    chk("ready_after_start", in_ready, 1);
    beat(16'sd2, 16'sd3, 16'sd4, 16'sd5, 1);
    chk("ready_low_flush", in_ready, 0);
    push_exp(32'd8, 32'd10, 32'd12, 32'd15, 1'b0, 1'b0);
    wait_idle();

    // k=3 ones with bubbles; start during COMPUTE ignored
    start_job(3);
    beat(16'sd1, 16'sd1, 16'sd1, 16'sd1, 1);
    start = 1'b1;
    k_len = KW'(9);
    beat(16'sd7, 16'sd7, 16'sd7, 16'sd7, 0);
    start = 1'b0;
    beat(16'sd1, 16'sd1, 16'sd1, 16'sd1, 1);
    beat(16'sd9, 16'sd9, 16'sd9, 16'sd9, 0);
    beat(16'sd1, 16'sd1, 16'sd1, 16'sd1, 1);
    push_exp(32'd3, 32'd3, 32'd3, 32'd3, 1'b0, 1'b0);
    wait_idle();

    // most-negative operands, k=2
    start_job(2);
    beat(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 1);
    beat(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 1);
`ifdef OS_SAT_EN
    push_exp(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
             1'b1, 1'b1);
`else
    push_exp(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
             1'b0, 1'b0);
`endif
    wait_idle();

    // back-pressure in DRAIN; start during FLUSH ignored
    out_ready = 1'b0;
    start_job(2);
    beat(16'sd1, -16'sd2, 16'sd3, 16'sd4, 1);
    beat(16'sd1, -16'sd2, 16'sd3, 16'sd4, 1);
    push_exp(32'd6, 32'd8, -32'sd12, -32'sd16, 1'b0, 1'b0);
    start = 1'b1;
    k_len = KW'(5);
    tick();
    start = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        tick();
        n++;
      end
    end
    chk("drain_reached", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_row", out_row, {32'd8, 32'd6});
      chk("stall_last", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    tick();
    tick();
    chk("start_ignored", busy, 0);

    // reset after 2 of 4 beats, then a fresh job
    start_job(4);
    beat(16'sd5, 16'sd5, 16'sd5, 16'sd5, 1);
    beat(16'sd5, 16'sd5, 16'sd5, 16'sd5, 1);
    rst = 1'b1;
    tick();
    chk("abort_flags", {busy, in_ready, out_valid, out_last, out_sat}, 0);
    chk("abort_row", out_row, 0);
    rst = 1'b0;
    tick();
    start_job(1);
    beat(16'sd1, 16'sd2, 16'sd3, 16'sd4, 1);
    push_exp(32'd3, 32'd4, 32'd6, 32'd8, 1'b0, 1'b0);
    wait_idle();

    // start with k_len=0 stays IDLE
    start = 1'b1;
    k_len = '0;
    tick();
    start = 1'b0;
    chk("k0_idle", {busy, in_ready}, 0);
    tick();
    chk("k0_still_idle", {busy, in_ready, out_valid}, 0);

    tick();
    tick();
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
